card_dealer_ctrl: RTL and testbench

- Sequences the rng core to deal cards from a single 52-card deck without replacement.
- Owns the rng control pins (seed load, seed value, enable) and keeps a dealt-card mask.
- Turns raw 32-bit rng words into unique card indices 0..51.
- Sits between the game FSM (deal/new-deck/seed requests) and the rng.

---
 rtl/card_dealer_ctrl_if.sv | 30 +++
 rtl/card_dealer_ctrl.sv | 132 +++++++++++++
 tb/tb_card_dealer_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/card_dealer_ctrl_if.sv
// Request, rng-control and card-result signals shared between the game FSM,
// the rng core and card_dealer_ctrl.
interface card_dealer_ctrl_if;
   logic [31:0] seed_i;
   logic        seed_load_i;
   logic        new_deck_i;
   logic        deal_req_i;
   logic [31:0] rng_number_i;
   logic        rng_loadseed_o;
   logic [31:0] rng_seed_o;
   logic        rng_enable_o;
   logic [5:0]  card_o;
   logic        card_valid_o;
   logic        deal_err_o;
   logic        busy_o;
   logic [5:0]  cards_left_o;
   logic        deck_empty_o;

   modport master (
      output seed_i, seed_load_i, new_deck_i, deal_req_i, rng_number_i,
      input  rng_loadseed_o, rng_seed_o, rng_enable_o, card_o, card_valid_o,
             deal_err_o, busy_o, cards_left_o, deck_empty_o
   );

   modport slave (
      input  seed_i, seed_load_i, new_deck_i, deal_req_i, rng_number_i,
      output rng_loadseed_o, rng_seed_o, rng_enable_o, card_o, card_valid_o,
             deal_err_o, busy_o, cards_left_o, deck_empty_o
   );
endinterface

// File: rtl/card_dealer_ctrl.sv
// Deals unique cards from a 52-card deck using rng draws with rejection,
// falling back to a linear scan of the dealt-card mask after MAX_TRIES misses.
module card_dealer_ctrl #(
   parameter int MAX_TRIES = 4,
   parameter int DECK_SIZE = 52
) (
   input  logic              clk,
   input  logic              reset,
   card_dealer_ctrl_if.slave bus
);

   localparam logic [5:0] DECK  = 6'(DECK_SIZE);
   localparam logic [4:0] TRIES = 5'(MAX_TRIES);

   typedef enum logic [2:0] {
      S_IDLE, S_SEED, S_STEP, S_WAIT, S_CHECK, S_SCAN, S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [DECK_SIZE-1:0] mask_q, mask_d;
   logic [5:0]           card_q, card_d;
   logic [5:0]           left_q, left_d;
   logic [31:0]          seed_q, seed_d;
   logic [3:0]           try_q, try_d;
   logic [5:0]           idx_q, idx_d;
   logic                 err_q, err_d;

   logic [5:0] cand;
   logic [4:0] try_inc;
   logic [5:0] idx_next;
   logic       unused_rng;

   assign cand       = bus.rng_number_i[5:0];
   assign unused_rng = ^bus.rng_number_i[31:6];
   assign try_inc    = {1'b0, try_q} + 5'd1;
   assign idx_next   = (idx_q == DECK - 6'd1) ? '0 : idx_q + 6'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         mask_q  <= '0;
         card_q  <= '0;
         left_q  <= DECK;
         seed_q  <= '0;
         try_q   <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         card_q  <= card_d;
         left_q  <= left_d;
         seed_q  <= seed_d;
         try_q   <= try_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      card_d  = card_q;
      left_d  = left_q;
      seed_d  = seed_q;
      try_d   = try_q;
      idx_d   = idx_q;
      err_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.new_deck_i) begin
               mask_d = '0;
               left_d = DECK;
            end else if (bus.seed_load_i) begin
               seed_d  = bus.seed_i;
               state_d = S_SEED;
            end else if (bus.deal_req_i) begin
               if (left_q == '0) begin
                  err_d = 1'b1;
               end else begin
                  try_d   = '0;
                  state_d = S_STEP;
               end
            end
         end
         S_SEED:  state_d = S_IDLE;
         S_STEP:  state_d = S_WAIT;
         S_WAIT:  state_d = S_CHECK;
         S_CHECK: begin
            if (cand < DECK && !mask_q[cand]) begin
               mask_d[cand] = 1'b1;
               card_d       = cand;
               left_d       = left_q - 6'd1;
               state_d      = S_DONE;
            end else begin
               try_d = try_inc[3:0];
               if (try_inc < TRIES) begin
                  state_d = S_STEP;
               end else begin
                  // out-of-range draws fold back into the deck to seed the scan
                  idx_d   = (cand < DECK) ? cand : cand - DECK;
                  state_d = S_SCAN;
               end
            end
         end
         S_SCAN: begin
            if (!mask_q[idx_q]) begin
               mask_d[idx_q] = 1'b1;
               card_d        = idx_q;
               left_d        = left_q - 6'd1;
               state_d       = S_DONE;
            end else begin
               idx_d = idx_next;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.rng_loadseed_o = (state_q == S_SEED);
   assign bus.rng_enable_o   = (state_q == S_STEP);
   assign bus.rng_seed_o     = seed_q;
   assign bus.card_o         = card_q;
   assign bus.card_valid_o   = (state_q == S_DONE);
   assign bus.deal_err_o     = err_q;
   assign bus.busy_o         = (state_q != S_IDLE);
   assign bus.cards_left_o   = left_q;
   assign bus.deck_empty_o   = (left_q == '0);

endmodule

// File: tb/tb_card_dealer_ctrl.sv
// Bench for card_dealer_ctrl: scripted rng stub, scoreboard of expected deals,
// table of single-deal vectors plus hand-written corner sequences.
module tb_card_dealer_ctrl;
   localparam int MAX_TRIES = 4;
   localparam int DECK_SIZE = 52;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   card_dealer_ctrl_if bus ();

   card_dealer_ctrl #(.MAX_TRIES(MAX_TRIES), .DECK_SIZE(DECK_SIZE)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // rng stub: scripted words first, then a free-running LCG
   logic [31:0] rng_word = '0;
   logic [31:0] lcg      = 32'h1;
   logic [31:0] script[$];
   always @(posedge clk) begin
      if (bus.rng_enable_o) begin
         if (script.size() > 0) begin
            rng_word <= script.pop_front();
         end else begin
            lcg = lcg * 32'd1664525 + 32'd1013904223;
            rng_word <= lcg;
         end
      end
   end
   assign bus.rng_number_i = rng_word;

   typedef struct {
      bit         is_err;
      bit         chk_card;
      logic [5:0] card;
      int         lat;
      logic [5:0] left;
      int         t0;
   } exp_t;
   exp_t sb[$];

   int          valid_cnt = 0;
   int          ls_cnt    = 0;
   bit [51:0]   seen      = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         chk("enable_and_loadseed", 32'(bus.rng_enable_o & bus.rng_loadseed_o), 32'd0);
         if (bus.rng_loadseed_o) ls_cnt++;
         if (bus.card_valid_o) begin
            valid_cnt++;
            if (sb.size() == 0 || sb[0].is_err) begin
               checks++;
               errors++;
               $display("FAIL unexpected_card_valid: got card %0d expected no card", bus.card_o);
            end else begin
               e = sb.pop_front();
               if (e.chk_card) begin
                  chk("card", 32'(bus.card_o), 32'(e.card));
               end else begin
                  chk("card_range", 32'(bus.card_o < 6'd52), 32'd1);
                  if (bus.card_o < 6'd52) begin
                     chk("card_unique", 32'(seen[bus.card_o]), 32'd0);
                     seen[bus.card_o] = 1'b1;
                  end
               end
               if (e.lat > 0) chk("deal_latency", 32'(cyc - e.t0), 32'(e.lat));
               chk("cards_left", 32'(bus.cards_left_o), 32'(e.left));
            end
         end
         if (bus.deal_err_o) begin
            if (sb.size() == 0 || !sb[0].is_err) begin
               checks++;
               errors++;
               $display("FAIL unexpected_deal_err: got 1 expected 0");
            end else begin
               e = sb.pop_front();
               chk("err_latency", 32'(cyc - e.t0), 32'd1);
               chk("err_cards_left", 32'(bus.cards_left_o), 32'(e.left));
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic deal(input bit is_err, input bit chkc, input logic [5:0] card,
                       input int lat, input logic [5:0] left);
      exp_t e;
      e.is_err   = is_err;
      e.chk_card = chkc;
      e.card     = card;
      e.lat      = lat;
      e.left     = left;
      e.t0       = cyc;
      sb.push_back(e);
      bus.deal_req_i = 1'b1;
      tick();
      bus.deal_req_i = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         if (sb.size() == 0 && !bus.busy_o) return;
         tick();
      end
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
   endtask

   task automatic new_deck();
      bus.new_deck_i = 1'b1;
      tick();
      bus.new_deck_i = 1'b0;
   endtask

   typedef struct {
      logic [0:3][31:0] w;
      int               nw;
      logic [5:0]       card;
      int               lat;
   } vec_t;
   vec_t tbl[6];

   initial begin
      int vc0;
      int ls0;
      tbl[0] = '{w: {32'h7, 32'h0, 32'h0, 32'h0},                        nw: 1, card: 6'd7,  lat: 4};
      tbl[1] = '{w: {32'h33, 32'h0, 32'h0, 32'h0},                       nw: 1, card: 6'd51, lat: 4};
      tbl[2] = '{w: {32'hABCDEF40, 32'h0, 32'h0, 32'h0},                 nw: 1, card: 6'd0,  lat: 4};
      tbl[3] = '{w: {32'h34, 32'h5, 32'h0, 32'h0},                       nw: 2, card: 6'd5,  lat: 7};
      tbl[4] = '{w: {32'h3F, 32'h3F, 32'h3F, 32'h3F},                    nw: 4, card: 6'd11, lat: 14};
      tbl[5] = '{w: {32'h35, 32'h36, 32'h37, 32'h33},                    nw: 4, card: 6'd51, lat: 13};

      bus.seed_i      = '0;
      bus.seed_load_i = 1'b0;
      bus.new_deck_i  = 1'b0;
      bus.deal_req_i  = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      chk("rst_card", 32'(bus.card_o), 32'd0);
      chk("rst_valid", 32'(bus.card_valid_o), 32'd0);
      chk("rst_err", 32'(bus.deal_err_o), 32'd0);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_left", 32'(bus.cards_left_o), 32'd52);
      chk("rst_empty", 32'(bus.deck_empty_o), 32'd0);
      chk("rst_seed", bus.rng_seed_o, 32'd0);
      chk("rst_loadseed", 32'(bus.rng_loadseed_o), 32'd0);
      chk("rst_enable", 32'(bus.rng_enable_o), 32'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         new_deck();
         for (int j = 0; j < tbl[i].nw; j++) script.push_back(tbl[i].w[j]);
         deal(1'b0, 1'b1, tbl[i].card, tbl[i].lat, 6'd51);
         wait_idle();
         chk("script_consumed", 32'(script.size()), 32'd0);
      end

      // first deal, seed load, then a rejection chain ending in the scan
      new_deck();
      script.push_back(32'h7);
      deal(1'b0, 1'b1, 6'd7, 4, 6'd51);
      wait_idle();
      bus.seed_i      = 32'h12345678;
      bus.seed_load_i = 1'b1;
      tick();
      bus.seed_load_i = 1'b0;
      bus.seed_i      = 32'hDEADBEEF;
      chk("seed_loadseed_hi", 32'(bus.rng_loadseed_o), 32'd1);
      chk("seed_value", bus.rng_seed_o, 32'h12345678);
      chk("seed_busy", 32'(bus.busy_o), 32'd1);
      tick();
      chk("seed_loadseed_lo", 32'(bus.rng_loadseed_o), 32'd0);
      chk("seed_hold", bus.rng_seed_o, 32'h12345678);
      chk("seed_idle", 32'(bus.busy_o), 32'd0);
      chk("seed_left", 32'(bus.cards_left_o), 32'd51);
      script.push_back(32'h7);
      script.push_back(32'h3F);
      script.push_back(32'h3E);
      script.push_back(32'h3D);
      deal(1'b0, 1'b1, 6'd9, 14, 6'd50);
      wait_idle();

      // scan starting on a dealt card wraps 51 -> 0
      new_deck();
      script.push_back(32'h33);
      deal(1'b0, 1'b1, 6'd51, 4, 6'd51);
      wait_idle();
      repeat (4) script.push_back(32'h33);
      deal(1'b0, 1'b1, 6'd0, 15, 6'd50);
      wait_idle();

      // simultaneous requests: only the deck clear takes effect
      bus.seed_i      = 32'hAAAA5555;
      bus.new_deck_i  = 1'b1;
      bus.seed_load_i = 1'b1;
      bus.deal_req_i  = 1'b1;
      tick();
      bus.new_deck_i  = 1'b0;
      bus.seed_load_i = 1'b0;
      bus.deal_req_i  = 1'b0;
      chk("prio_left", 32'(bus.cards_left_o), 32'd52);
      chk("prio_busy", 32'(bus.busy_o), 32'd0);
      chk("prio_loadseed", 32'(bus.rng_loadseed_o), 32'd0);
      chk("prio_enable", 32'(bus.rng_enable_o), 32'd0);
      tick();
      chk("prio_seed", bus.rng_seed_o, 32'h12345678);
      chk("prio_busy2", 32'(bus.busy_o), 32'd0);
      script.push_back(32'h0);
      deal(1'b0, 1'b1, 6'd0, 4, 6'd51);
      wait_idle();

      // requests while busy are dropped
      vc0 = valid_cnt;
      ls0 = ls_cnt;
      script.push_back(32'h5);
      deal(1'b0, 1'b1, 6'd5, 4, 6'd50);
      chk("busy_step_busy", 32'(bus.busy_o), 32'd1);
      chk("busy_step_enable", 32'(bus.rng_enable_o), 32'd1);
      bus.deal_req_i  = 1'b1;
      bus.seed_load_i = 1'b1;
      bus.new_deck_i  = 1'b1;
      tick();
      bus.deal_req_i  = 1'b0;
      bus.seed_load_i = 1'b0;
      bus.new_deck_i  = 1'b0;
      wait_idle();
      repeat (6) tick();
      chk("busy_one_card", 32'(valid_cnt - vc0), 32'd1);
      chk("busy_no_seed", 32'(ls_cnt - ls0), 32'd0);
      chk("busy_left", 32'(bus.cards_left_o), 32'd50);
      chk("busy_seed_val", bus.rng_seed_o, 32'h12345678);

      // reset during WAIT aborts the deal
      vc0 = valid_cnt;
      script.push_back(32'h9);
      bus.deal_req_i = 1'b1;
      tick();
      bus.deal_req_i = 1'b0;
      tick();
      chk("abort_busy", 32'(bus.busy_o), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      script.delete();
      repeat (6) tick();
      chk("abort_no_valid", 32'(valid_cnt - vc0), 32'd0);
      chk("abort_left", 32'(bus.cards_left_o), 32'd52);
      chk("abort_busy_lo", 32'(bus.busy_o), 32'd0);
      chk("abort_card", 32'(bus.card_o), 32'd0);

      // whole deck from the free-running stub, then one deal too many
      seen = '0;
      for (int i = 0; i < 52; i++) begin
         deal(1'b0, 1'b0, 6'd0, 0, 6'(51 - i));
         wait_idle();
      end
      chk("all_seen", 32'(&seen), 32'd1);
      chk("full_empty", 32'(bus.deck_empty_o), 32'd1);
      chk("full_left", 32'(bus.cards_left_o), 32'd0);
      vc0 = valid_cnt;
      deal(1'b1, 1'b0, 6'd0, 0, 6'd0);
      wait_idle();
      repeat (4) tick();
      chk("err_no_valid", 32'(valid_cnt - vc0), 32'd0);
      chk("err_idle", 32'(bus.busy_o), 32'd0);
      chk("err_left", 32'(bus.cards_left_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

endmodule
